dr_byte_loader: RTL and testbench

Byte-serial load sequencer that sits directly upstream of the 32-bit data register (DR). On a load request it fetches one or four bytes from the byte-wide memory, then presents each byte on DR's 8-bit input with the matching enable and function select. At completion, DR holds a sign-extended byte, a zero-extended byte, a big-endian word or a little-endian word. Only this block drives DR's I/E/FunSel inputs.

---
 rtl/dr_byte_loader_pkg.sv | 26 ++
 rtl/dr_byte_loader.sv | 149 ++++++++++++++
 tb/tb_dr_byte_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dr_byte_loader_pkg.sv
// Shared definitions for the DR byte-load sequencer: mode encodings (identical
// to DR's FunSel codes), FSM state enum and small mode-decoding helpers.
package dr_byte_loader_pkg;

  localparam logic [1:0] MODE_BYTE_S  = 2'b00;
  localparam logic [1:0] MODE_BYTE_U  = 2'b01;
  localparam logic [1:0] MODE_WORD_BE = 2'b10;
  localparam logic [1:0] MODE_WORD_LE = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  function automatic logic is_word_mode(input logic [1:0] mode);
    return mode[1];
  endfunction

  function automatic logic [2:0] bytes_needed(input logic [1:0] mode);
    return is_word_mode(mode) ? 3'd4 : 3'd1;
  endfunction

endpackage

// File: rtl/dr_byte_loader.sv
// Byte-serial load sequencer feeding the 32-bit data register: fetches one or
// four bytes from byte-wide memory and presents each with a one-cycle DR enable.
module dr_byte_loader
  import dr_byte_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [1:0]        Mode,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRead,
  input  logic [7:0]        MemData,
  input  logic              MemValid,
  output logic [7:0]        DR_I,
  output logic              DR_E,
  output logic [1:0]        DR_FunSel,
  output logic              Busy,
  output logic              Done,
  output logic              AlignErr
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [2:0]          count_q, count_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_read_q, mem_read_d;
  logic [7:0]          dr_i_q, dr_i_d;
  logic                dr_e_q, dr_e_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                align_err_q, align_err_d;
  logic [2:0]          count_inc;

  assign count_inc = count_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    count_d     = count_q;
    mode_d      = mode_q;
    mem_addr_d  = mem_addr_q;
    mem_read_d  = mem_read_q;
    dr_i_d      = dr_i_q;
    busy_d      = busy_q;
    dr_e_d      = 1'b0;
    done_d      = 1'b0;
    align_err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          base_d  = Addr;
          mode_d  = Mode;
          count_d = 3'd0;
          busy_d  = 1'b1;
          // Misaligned word requests are rejected before any memory access.
          if (is_word_mode(Mode) && (Addr[1:0] != 2'b00)) begin
            state_d     = ERR;
            align_err_d = 1'b1;
          end else begin
            state_d    = REQ;
            mem_read_d = 1'b1;
            mem_addr_d = Addr;
          end
        end
      end

      REQ: begin
        if (MemValid) begin
          state_d    = WRITE;
          mem_read_d = 1'b0;
          dr_e_d     = 1'b1;
          dr_i_d     = MemData;
        end
      end

      WRITE: begin
        count_d = count_inc;
        if (count_inc == bytes_needed(mode_q)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = REQ;
          mem_read_d = 1'b1;
          mem_addr_d = base_q + ADDR_W'(count_inc);
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      ERR: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        mem_read_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      count_q     <= 3'd0;
      mode_q      <= 2'b00;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      dr_i_q      <= 8'h00;
      dr_e_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      mem_addr_q  <= mem_addr_d;
      mem_read_q  <= mem_read_d;
      dr_i_q      <= dr_i_d;
      dr_e_q      <= dr_e_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      align_err_q <= align_err_d;
    end
  end

  // The latched mode doubles as DR's function select; the codes are identical.
  assign MemAddr   = mem_addr_q;
  assign MemRead   = mem_read_q;
  assign DR_I      = dr_i_q;
  assign DR_E      = dr_e_q;
  assign DR_FunSel = mode_q;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign AlignErr  = align_err_q;

endmodule

// File: tb/tb_dr_byte_loader.sv
// Directed bench for dr_byte_loader with a behavioural memory and DR model.
module tb_dr_byte_loader;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] Addr  = 16'h0000;
  logic [1:0]  Mode  = 2'b00;
  logic [15:0] MemAddr;
  logic        MemRead;
  logic [7:0]  MemData = 8'h00;
  logic        MemValid = 1'b0;
  logic [7:0]  DR_I;
  logic        DR_E;
  logic [1:0]  DR_FunSel;
  logic        Busy;
  logic        Done;
  logic        AlignErr;

  dr_byte_loader #(.ADDR_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Addr(Addr), .Mode(Mode),
    .MemAddr(MemAddr), .MemRead(MemRead), .MemData(MemData), .MemValid(MemValid),
    .DR_I(DR_I), .DR_E(DR_E), .DR_FunSel(DR_FunSel),
    .Busy(Busy), .Done(Done), .AlignErr(AlignErr)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model: responds after wait_cfg REQ cycles; optional stray MemValid when idle.
  logic [7:0]  mem [0:65535];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic        stray = 1'b0;
  logic [15:0] addr_log [0:15];
  int          n_addr = 0;

  always @(negedge Clock) begin
    if (MemRead) begin
      if (wait_cnt >= wait_cfg) begin
        MemValid = 1'b1;
        MemData  = mem[MemAddr];
        if (n_addr < 16) addr_log[n_addr] = MemAddr;
        n_addr++;
      end else begin
        MemValid = 1'b0;
        MemData  = 8'hEE;
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      MemValid = stray;
      MemData  = 8'h5A;
    end
  end

  // Behavioural model of the downstream 32-bit DR.
  logic [31:0] dr_model = 32'hDEAD_BEEF;
  always @(posedge Clock) begin
    if (DR_E) begin
      case (DR_FunSel)
        2'b00: dr_model <= {{24{DR_I[7]}}, DR_I};
        2'b01: dr_model <= {24'h0, DR_I};
        2'b10: dr_model <= {dr_model[23:0], DR_I};
        default: dr_model <= {DR_I, dr_model[31:8]};
      endcase
    end
  end

  int          done_cyc, err_cyc, n_e, n_rd;
  logic        busy_gap;
  logic [7:0]  last_dr_i;
  logic [1:0]  last_fs;

  task automatic run_load(input logic [1:0] m, input logic [15:0] a, input int waits,
                          input logic pulse);
    @(negedge Clock);
    wait_cfg = waits; n_addr = 0;
    done_cyc = -1; err_cyc = -1; n_e = 0; n_rd = 0; busy_gap = 1'b0;
    last_dr_i = 8'h00; last_fs = 2'b00;
    Mode = m; Addr = a; Start = 1'b1;
    for (int c = 1; c < 200; c++) begin
      @(negedge Clock);
      Start = pulse && (c % 3 == 0);
      if (pulse) begin
        Addr = 16'hABCD;
        Mode = ~m;
      end
      if (DR_E) begin
        n_e++;
        last_dr_i = DR_I;
        last_fs   = DR_FunSel;
      end
      if (MemRead) n_rd++;
      if (!Busy) busy_gap = 1'b1;
      if (Done) begin done_cyc = c; break; end
      if (AlignErr) begin err_cyc = c; break; end
    end
    Start = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge Clock);
    n_checks++;
    if ({MemAddr, MemRead, DR_I, DR_E, DR_FunSel, Busy, Done, AlignErr} !== 31'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0",
               {MemAddr, MemRead, DR_I, DR_E, DR_FunSel, Busy, Done, AlignErr});
    end
    Reset = 1'b0;
    $display("test_reset: outputs after reset checked");
  endtask

  task automatic test_byte_signed();
    mem[16'h0010] = 8'h85;
    run_load(2'b00, 16'h0010, 0, 1'b0);
    n_checks++;
    if (done_cyc !== 3) begin n_fail++; $display("FAIL bs_done_cycle: got %0d required 3", done_cyc); end
    n_checks++;
    if (n_e !== 1 || last_dr_i !== 8'h85 || last_fs !== 2'b00) begin
      n_fail++;
      $display("FAIL bs_dr_write: got n=%0d I=%h fs=%b required n=1 I=85 fs=00", n_e, last_dr_i, last_fs);
    end
    n_checks++;
    if (dr_model !== 32'hFFFF_FF85) begin n_fail++; $display("FAIL bs_dr_value: got %h required ffffff85", dr_model); end
    $display("test_byte_signed: done cycle %0d DR=%h", done_cyc, dr_model);
  endtask

  task automatic test_word_be();
    mem[16'h0100] = 8'h12; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h56; mem[16'h0103] = 8'h78;
    run_load(2'b10, 16'h0100, 0, 1'b0);
    n_checks++;
    if (done_cyc !== 9) begin n_fail++; $display("FAIL be_done_cycle: got %0d required 9", done_cyc); end
    n_checks++;
    if (dr_model !== 32'h1234_5678) begin n_fail++; $display("FAIL be_dr_value: got %h required 12345678", dr_model); end
    n_checks++;
    if (n_addr !== 4 || addr_log[0] !== 16'h0100 || addr_log[1] !== 16'h0101 ||
        addr_log[2] !== 16'h0102 || addr_log[3] !== 16'h0103) begin
      n_fail++;
      $display("FAIL be_mem_addr: got n=%0d %h %h %h %h required 4 0100..0103",
               n_addr, addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
    end
    n_checks++;
    if (n_e !== 4 || n_rd !== 4 || busy_gap !== 1'b0) begin
      n_fail++;
      $display("FAIL be_counts: got dr_e=%0d rd=%0d gap=%b required 4 4 0", n_e, n_rd, busy_gap);
    end
    $display("test_word_be: done cycle %0d DR=%h", done_cyc, dr_model);
  endtask

  task automatic test_word_le_wait();
    stray = 1'b1;
    run_load(2'b11, 16'h0100, 2, 1'b1);
    stray = 1'b0;
    n_checks++;
    if (done_cyc !== 17) begin n_fail++; $display("FAIL le_done_cycle: got %0d required 17", done_cyc); end
    n_checks++;
    if (dr_model !== 32'h7856_3412) begin n_fail++; $display("FAIL le_dr_value: got %h required 78563412", dr_model); end
    n_checks++;
    if (n_e !== 4 || n_rd !== 12 || last_fs !== 2'b11) begin
      n_fail++;
      $display("FAIL le_counts: got dr_e=%0d rd=%0d fs=%b required 4 12 11", n_e, n_rd, last_fs);
    end
    @(negedge Clock);
    n_checks++;
    if (Busy !== 1'b0 || MemRead !== 1'b0) begin
      n_fail++;
      $display("FAIL le_no_queue: got busy=%b rd=%b required 0 0", Busy, MemRead);
    end
    $display("test_word_le_wait: done cycle %0d DR=%h", done_cyc, dr_model);
  endtask

  task automatic test_align_err();
    logic [31:0] dr_before;
    dr_before = dr_model;
    run_load(2'b10, 16'h0102, 0, 1'b0);
    n_checks++;
    if (err_cyc !== 1 || done_cyc !== -1) begin
      n_fail++;
      $display("FAIL ae_cycle: got err=%0d done=%0d required 1 -1", err_cyc, done_cyc);
    end
    n_checks++;
    if (n_rd !== 0 || n_e !== 0 || n_addr !== 0) begin
      n_fail++;
      $display("FAIL ae_no_access: got rd=%0d dr_e=%0d mem=%0d required 0 0 0", n_rd, n_e, n_addr);
    end
    @(negedge Clock);
    n_checks++;
    if (Busy !== 1'b0 || AlignErr !== 1'b0 || MemRead !== 1'b0 || DR_E !== 1'b0) begin
      n_fail++;
      $display("FAIL ae_cycle2: got busy=%b ae=%b rd=%b e=%b required 0 0 0 0", Busy, AlignErr, MemRead, DR_E);
    end
    n_checks++;
    if (dr_model !== dr_before) begin n_fail++; $display("FAIL ae_dr_kept: got %h required %h", dr_model, dr_before); end
    $display("test_align_err: AlignErr cycle %0d", err_cyc);
  endtask

  task automatic test_byte_unsigned_top();
    mem[16'hFFFF] = 8'hC3;
    run_load(2'b01, 16'hFFFF, 1, 1'b0);
    n_checks++;
    if (n_addr !== 1 || addr_log[0] !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL bu_mem_addr: got n=%0d %h required 1 ffff", n_addr, addr_log[0]);
    end
    n_checks++;
    if (dr_model !== 32'h0000_00C3) begin n_fail++; $display("FAIL bu_dr_value: got %h required 000000c3", dr_model); end
    n_checks++;
    if (done_cyc !== 4) begin n_fail++; $display("FAIL bu_done_cycle: got %0d required 4", done_cyc); end
    $display("test_byte_unsigned_top: done cycle %0d DR=%h", done_cyc, dr_model);
  endtask

  task automatic test_reset_mid_word();
    int  seen_e;
    logic saw_done;
    seen_e = 0; saw_done = 1'b0;
    wait_cfg = 0;
    @(negedge Clock);
    Mode = 2'b10; Addr = 16'h0100; Start = 1'b1;
    for (int c = 1; c < 50; c++) begin
      @(negedge Clock);
      Start = 1'b0;
      if (Done) saw_done = 1'b1;
      if (DR_E) seen_e++;
      if (seen_e == 2) break;
    end
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    if (Done) saw_done = 1'b1;
    n_checks++;
    if ({MemAddr, MemRead, DR_I, DR_E, DR_FunSel, Busy, Done, AlignErr} !== 31'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %h required 0",
               {MemAddr, MemRead, DR_I, DR_E, DR_FunSel, Busy, Done, AlignErr});
    end
    n_checks++;
    if (seen_e !== 2 || saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_progress: got dr_e=%0d done=%b required 2 0", seen_e, saw_done);
    end
    Reset = 1'b0;
    mem[16'h0020] = 8'h7F;
    run_load(2'b00, 16'h0020, 0, 1'b0);
    n_checks++;
    if (done_cyc !== 3 || dr_model !== 32'h0000_007F) begin
      n_fail++;
      $display("FAIL rst_mid_restart: got done=%0d DR=%h required 3 0000007f", done_cyc, dr_model);
    end
    $display("test_reset_mid_word: restart done cycle %0d DR=%h", done_cyc, dr_model);
  endtask

  initial begin
    test_reset();
    test_byte_signed();
    test_word_be();
    test_word_le_wait();
    test_align_err();
    test_byte_unsigned_top();
    test_reset_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
